// File: rtl/sm3_pkg.sv
// sm3_pkg: SM3 widths, initial chaining value and sequencer state encoding.
package sm3_pkg;
  localparam int WORD_W = 32;
  localparam int V_W = 8 * WORD_W;
  localparam int BLOCK_W = 512;
  localparam logic [V_W-1:0] IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  typedef enum logic [2:0] {IDLE, PAD, LOAD, COMP, UPDATE, FIN} state_t;
endpackage

// File: rtl/sm3_block_count.sv
// sm3_block_count: number of padded 512-bit blocks for a message of length bits.
module sm3_block_count
  import sm3_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic [LEN_W-1:0] length,
  output logic [LEN_W:0]   count
);
  logic [LEN_W:0] sum;
  // ceil((L + 65) / 512) == (L + 576) >> 9, one extra bit keeps L = 2^LEN_W-1 exact
  assign sum = {1'b0, length} + (LEN_W+1)'(BLOCK_W + 64);
  assign count = sum >> $clog2(BLOCK_W);
endmodule

// File: rtl/sm3_block_sequencer.sv
// sm3_block_sequencer: walks padder and compression function through every block of one SM3 hash.
module sm3_block_sequencer
  import sm3_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   length,
  output logic               pad_en,
  input  logic               pad_done,
  input  logic [BLOCK_W-1:0] pad_block,
  output logic               cf_en,
  output logic [V_W-1:0]     cf_v,
  output logic [BLOCK_W-1:0] cf_block,
  input  logic               cf_done,
  input  logic [V_W-1:0]     cf_out,
  output logic               busy,
  output logic               done,
  output logic [V_W-1:0]     digest
);
  state_t         state;
  logic [LEN_W:0] blocks_left;
  logic [LEN_W:0] count;

  sm3_block_count #(.LEN_W(LEN_W)) u_count (.length(length), .count(count));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pad_en <= 1'b0;
      cf_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      digest <= '0;
      cf_v <= IV;
      cf_block <= '0;
      blocks_left <= '0;
    end else if (abort) begin
      state <= IDLE;
      pad_en <= 1'b0;
      cf_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cf_v <= IV;
          blocks_left <= count;
          pad_en <= 1'b1;
          busy <= 1'b1;
          state <= PAD;
        end
        PAD: if (pad_done) begin
          cf_block <= pad_block;
          pad_en <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          cf_en <= 1'b1;
          state <= COMP;
        end
        COMP: if (cf_done) begin
          cf_en <= 1'b0;
          state <= UPDATE;
        end
        UPDATE: begin
          cf_v <= cf_out;
          blocks_left <= blocks_left - (LEN_W+1)'(1);
          if (blocks_left == (LEN_W+1)'(1)) begin
            digest <= cf_out;
            done <= 1'b1;
            state <= FIN;
          end else begin
            pad_en <= 1'b1;
            state <= PAD;
          end
        end
        FIN: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sm3_block_sequencer.sv
// tb_sm3_block_sequencer: drives the sequencer with bench padder and SM3 compression models.
module tb_sm3_block_sequencer;
  import sm3_pkg::*;

  localparam logic [255:0] DIG_ABC = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] DIG_ABCD = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

  logic clk = 0, rst = 0, start = 0, abort = 0, pad_done = 0, cf_done_m = 0, spur = 0;
  logic [63:0] length = '0;
  logic [511:0] pad_block = '0;
  logic [255:0] cf_out = '0;
  logic pad_en, cf_en, busy, done;
  logic [255:0] cf_v, digest;
  logic [511:0] cf_block;
  logic [63:0] bc_len = '0;
  logic [64:0] bc_cnt;

  int vectors = 0, errors = 0;
  int cf_bursts = 0, pad_bursts = 0, done_cnt = 0, bi = 0;
  logic pcf = 0, ppad = 0, pdone = 0;

  logic [511:0] eb[2];
  logic [255:0] ev[3];
  int en = 0;
  logic [255:0] edig = '0;

  always #5 clk = ~clk;

  sm3_block_sequencer #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .length(length),
    .pad_en(pad_en), .pad_done(pad_done), .pad_block(pad_block),
    .cf_en(cf_en), .cf_v(cf_v), .cf_block(cf_block),
    .cf_done(cf_done_m | spur), .cf_out(cf_out),
    .busy(busy), .done(done), .digest(digest)
  );

  sm3_block_count #(.LEN_W(64)) u_bc (.length(bc_len), .count(bc_cnt));

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] p0f(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction
  function automatic logic [31:0] p1f(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // reference SM3 compression CF(V, B)
  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w[68];
    logic [31:0] wp[64];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, ff, gg, t;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1f(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rl(rl(a, 12) + e + rl(t, j % 32), 7);
      ss2 = ss1 ^ rl(a, 12);
      ff = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + wp[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rl(bb, 9); bb = a; a = tt1;
      h = g; g = rl(f, 19); f = e; e = p0f(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  // pads a top-aligned message of L bits and precomputes every chaining value
  task automatic prep(input int L, input logic [1023:0] msg);
    logic [1023:0] p;
    int total;
    en = (L + 65 + 511) / 512;
    total = en * 512;
    p = '0;
    for (int i = 0; i < L; i++) p[1023-i] = msg[1023-i];
    p[1023-L] = 1'b1;
    p[1023-total+1 +: 64] = 64'(L);
    for (int k = 0; k < en; k++) eb[k] = p[1023-512*k -: 512];
    ev[0] = IV;
    for (int k = 0; k < en; k++) ev[k+1] = sm3_cf(ev[k], eb[k]);
    edig = ev[en];
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // padding unit: answers pad_en after three cycles with the next padded block
  initial begin
    int pidx = 0, pc = 0;
    forever begin
      @(negedge clk);
      if (pad_done) pad_done = 1'b0;
      else if (!busy) begin pidx = 0; pc = 0; end
      else if (pad_en) begin
        if (pc == 2) begin
          pad_block = eb[pidx & 1];
          pidx++;
          pad_done = 1'b1;
          pc = 0;
        end else pc++;
      end
    end
  end

  // compression unit: answers cf_en after four cycles, holds cf_out afterwards
  initial begin
    int cc = 0;
    forever begin
      @(negedge clk);
      if (cf_done_m) cf_done_m = 1'b0;
      else if (!cf_en) cc = 0;
      else if (cc == 3) begin
        cf_out = sm3_cf(cf_v, cf_block);
        cf_done_m = 1'b1;
        cc = 0;
      end else cc++;
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("enable_overlap", pad_en && cf_en, 0);
      chk("enable_while_idle", !busy && (pad_en || cf_en), 0);
      if (cf_en && !pcf) cf_bursts++;
      if (pad_en && !ppad) pad_bursts++;
      if (cf_en) begin
        chk("cf_v", cf_v, ev[bi % 3]);
        chk("cf_block", cf_block, eb[bi % 2]);
      end
      if (pcf && !cf_en) bi++;
      if (!busy) bi = 0;
      if (done) begin
        done_cnt++;
        chk("digest_at_done", digest, edig);
        chk("blocks_at_done", bi, en);
        chk("done_width", pdone, 0);
      end
      pcf = cf_en;
      ppad = pad_en;
      pdone = done;
    end
  end

  task automatic wait_for(input string nm, input int sel);
    int k = 0;
    while (!((sel == 0) ? done : (sel == 1) ? cf_en : pad_en) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, k < 3000, 1);
  endtask

  task automatic run(input int L, input logic [1023:0] msg, input int nlit, input logic odd,
                     output logic [255:0] dig);
    int c0, q0, d0;
    prep(L, msg);
    chk("model_block_count", en, nlit);
    c0 = cf_bursts; q0 = pad_bursts; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; length = 64'(L); spur = odd;
    @(negedge clk);
    spur = 1'b0;
    if (odd) begin
      length = 64'd1000;
      @(negedge clk);
    end
    start = 1'b0;
    wait_for("done_timeout", 0);
    dig = digest;
    @(negedge clk);
    chk("idle_after_fin", {busy, done}, 0);
    chk("cf_bursts", cf_bursts - c0, nlit);
    chk("pad_bursts", pad_bursts - q0, nlit);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic chk_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_pad_en", pad_en, 0);
    chk("rst_cf_en", cf_en, 0);
    chk("rst_done", done, 0);
    chk("rst_digest", digest, 0);
    chk("rst_cf_v", cf_v, IV);
    chk("rst_cf_block", cf_block, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1023:0] m_abc, m_abcd, m_x;
    logic [255:0] d, prev;
    logic [63:0] bl[6];
    logic [64:0] bx[6];
    int d0;
    m_abc = {24'h616263, 1000'd0};
    m_abcd = {{16{32'h61626364}}, 512'd0};
    m_x = {32{32'ha5c30f96}};
    bl = '{64'd0, 64'd447, 64'd448, 64'd512, 64'd960, 64'hffff_ffff_ffff_ffff};
    bx = '{65'd1, 65'd1, 65'd2, 65'd2, 65'd3, 65'h80_0000_0000_0001};
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state();
    for (int i = 0; i < 6; i++) begin
      bc_len = bl[i];
      #1 chk("block_count", bc_cnt, bx[i]);
    end
    rst = 1'b0;
    @(negedge clk);
    run(24, m_abc, 1, 1'b0, d);
    chk("abc_digest", d, DIG_ABC);
    run(512, m_abcd, 2, 1'b0, d);
    chk("abcd16_digest", d, DIG_ABCD);
    run(447, m_x, 1, 1'b0, d);
    run(448, m_x, 2, 1'b0, d);
    run(0, m_x, 1, 1'b0, prev);
    // abort in the middle of block 1 of 2
    prep(512, m_abcd);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; length = 64'd512;
    @(negedge clk);
    start = 1'b0;
    wait_for("cf_en_timeout", 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cf_en", cf_en, 0);
    chk("abort_pad_en", pad_en, 0);
    chk("abort_done", done, 0);
    chk("abort_digest", digest, prev);
    @(negedge clk);
    start = 1'b1; length = 64'd24;
    @(posedge clk);
    #1 chk("abort_beats_start", busy, 0);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_digest_kept", digest, prev);
    run(512, m_abcd, 2, 1'b0, d);
    chk("after_abort_digest", d, DIG_ABCD);
    // spurious cf_done alongside start, plus a start while busy
    run(24, m_abc, 1, 1'b1, d);
    chk("spurious_digest", d, DIG_ABC);
    // asynchronous reset in the middle of PAD
    prep(512, m_abcd);
    @(negedge clk);
    start = 1'b1; length = 64'd512;
    @(negedge clk);
    start = 1'b0;
    wait_for("pad_en_timeout", 2);
    #2 rst = 1'b1;
    #1 chk_reset_state();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(24, m_abc, 1, 1'b0, d);
    chk("after_reset_digest", d, DIG_ABC);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
